crc_frame_serializer: RTL and testbench

- Sits directly downstream of the parallel CRC engine.
- Captures each DWIDTH data word at the moment it is handed to the engine, then waits for the engine's crcReady rising edge and samples crcOut.
- Emits a byte stream over a valid/ready handshake: the data word's bytes followed by the CRC bytes, with a last-byte marker. This is the transmit framer feeding the link/UART layer.

---
 rtl/crc_frame_serializer.sv | 149 ++++++++++++++
 tb/tb_crc_frame_serializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_serializer.sv
// Transmit framer: captures a data word on load, waits for the CRC engine's ready edge,
// then streams the word bytes followed by the CRC bytes (MSB first) over valid/ready.
module crc_frame_serializer #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned CRC_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_data_load,
    input  logic [DWIDTH-1:0]    i_data_in,
    input  logic [CRC_WIDTH-1:0] i_crc_out,
    input  logic                 i_crc_ready,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_tx_last,
    output logic                 o_busy,
    output logic                 o_overrun_err,
    output logic                 o_timeout_err
);

    localparam int unsigned DBYTES = DWIDTH / 8;
    localparam int unsigned CBYTES = CRC_WIDTH / 8;
    localparam int unsigned MAXB   = (DBYTES > CBYTES) ? DBYTES : CBYTES;
    localparam int unsigned IDX_W  = $clog2(MAXB + 1);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StWaitCrc, StSendData, StSendCrc} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [DWIDTH-1:0]    r_word;
    logic [CRC_WIDTH-1:0] r_crc;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic [IDX_W-1:0]     r_byte_idx;
    logic                 r_crc_ready;
    logic                 r_overrun_err;
    logic                 r_timeout_err;

    logic w_crc_rise;
    logic w_xfer;
    logic w_wait_expired;
    logic w_last_data;
    logic w_last_crc;

    assign w_crc_rise     = i_crc_ready & ~r_crc_ready;
    assign w_xfer         = o_tx_valid & i_tx_ready;
    assign w_wait_expired = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
    assign w_last_data    = (r_byte_idx == IDX_W'(DBYTES - 1));
    assign w_last_crc     = (r_byte_idx == IDX_W'(CBYTES - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_data_load) w_state_next = StWaitCrc;
            end
            StWaitCrc: begin
                // A rising edge in the final wait cycle still wins over the timeout.
                if (w_crc_rise)          w_state_next = StSendData;
                else if (w_wait_expired) w_state_next = StIdle;
            end
            StSendData: begin
                if (w_xfer && w_last_data) w_state_next = StSendCrc;
            end
            StSendCrc: begin
                if (w_xfer && w_last_crc) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_tx_valid = 1'b0;
        o_tx_last  = 1'b0;
        o_tx_data  = 8'h00;
        o_busy     = (r_state != StIdle);
        case (r_state)
            StSendData: begin
                o_tx_valid = 1'b1;
                o_tx_data  = r_word[DWIDTH-1 -: 8];
            end
            StSendCrc: begin
                o_tx_valid = 1'b1;
                o_tx_data  = r_crc[CRC_WIDTH-1 -: 8];
                o_tx_last  = w_last_crc;
            end
            default: ;
        endcase
    end

    assign o_overrun_err = r_overrun_err;
    assign o_timeout_err = r_timeout_err;

    // Word and CRC are shifted left on each transfer so the top byte is always the one on the bus.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_word        <= '0;
            r_crc         <= '0;
            r_wait_cnt    <= '0;
            r_byte_idx    <= '0;
            r_crc_ready   <= 1'b1;
            r_overrun_err <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_crc_ready   <= i_crc_ready;
            r_overrun_err <= i_data_load && (r_state != StIdle);
            r_timeout_err <= (r_state == StWaitCrc) && !w_crc_rise && w_wait_expired;
            case (r_state)
                StIdle: begin
                    if (i_data_load) begin
                        r_word     <= i_data_in;
                        r_wait_cnt <= '0;
                    end
                end
                StWaitCrc: begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    if (w_crc_rise) begin
                        r_crc      <= i_crc_out;
                        r_byte_idx <= '0;
                    end
                end
                StSendData: begin
                    if (w_xfer) begin
                        r_word     <= r_word << 8;
                        r_byte_idx <= w_last_data ? '0 : r_byte_idx + IDX_W'(1);
                    end
                end
                StSendCrc: begin
                    if (w_xfer) begin
                        r_crc      <= r_crc << 8;
                        r_byte_idx <= w_last_crc ? '0 : r_byte_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Directed bench for crc_frame_serializer: basic frame, backpressure, overrun, timeout,
// spurious IDLE edge and mid-frame reset, each against hand-computed byte sequences.
module tb_crc_frame_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_load;
    logic [31:0] data_in;
    logic [15:0] crc_out;
    logic        crc_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic        overrun_err;
    logic        timeout_err;

    int n_asserts = 0;
    int n_fail    = 0;

    crc_frame_serializer #(
        .DWIDTH   (32),
        .CRC_WIDTH(16),
        .TIMEOUT  (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data_load  (data_load),
        .i_data_in    (data_in),
        .i_crc_out    (crc_out),
        .i_crc_ready  (crc_ready),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_tx_last    (tx_last),
        .o_busy       (busy),
        .o_overrun_err(overrun_err),
        .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] exp_data, input logic exp_last);
        chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
        chk({tag, "_data"}, 32'(tx_data), 32'(exp_data));
        chk({tag, "_last"}, 32'(tx_last), 32'(exp_last));
    endtask

    logic [7:0] basic_exp [6] = '{8'h9a, 8'hbc, 8'hde, 8'hf0, 8'h12, 8'h34};
    logic [7:0] bp_exp    [6] = '{8'haa, 8'haa, 8'h55, 8'h55, 8'hbe, 8'hef};
    logic [7:0] ovr_exp   [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] rst_exp   [6] = '{8'hca, 8'hfe, 8'hf0, 8'h0d, 8'h0f, 8'h0f};
    logic       bp_pat    [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int idx;

        rst       = 1'b1;
        data_load = 1'b0;
        data_in   = '0;
        crc_out   = '0;
        crc_ready = 1'b1;
        tx_ready  = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        step();
        // crcReady already high at release must not be taken as an edge.
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_errs", {30'd0, overrun_err, timeout_err}, 32'd0);

        // Basic frame
        data_load = 1'b1;
        data_in   = 32'h9abcdef0;
        crc_ready = 1'b0;
        step();
        data_load = 1'b0;
        chk("basic_busy_rise", 32'(busy), 32'd1);
        chk("basic_wait_valid", 32'(tx_valid), 32'd0);
        step();
        step();
        crc_ready = 1'b1;
        crc_out   = 16'h1234;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_byte($sformatf("basic_b%0d", i), basic_exp[i], i == 5);
        end
        step();
        chk("basic_end_valid", 32'(tx_valid), 32'd0);
        chk("basic_end_busy", 32'(busy), 32'd0);
        chk("basic_end_last", 32'(tx_last), 32'd0);

        // Minimum turnaround: load in the first IDLE cycle, then backpressure frame
        data_load = 1'b1;
        data_in   = 32'haaaa5555;
        crc_ready = 1'b0;
        step();
        data_load = 1'b0;
        chk("turn_busy", 32'(busy), 32'd1);
        chk("turn_no_overrun", 32'(overrun_err), 32'd0);
        step();
        crc_ready = 1'b1;
        crc_out   = 16'hbeef;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (idx < 6) begin
                tx_ready = bp_pat[c];
                chk_byte($sformatf("bp_c%0d", c), bp_exp[idx], idx == 5);
                if (bp_pat[c]) idx++;
            end
        end
        chk("bp_count", 32'(idx), 32'd6);
        tx_ready = 1'b1;
        step();
        chk("bp_end_valid", 32'(tx_valid), 32'd0);

        // Overrun during SEND_DATA
        data_load = 1'b1;
        data_in   = 32'h11223344;
        crc_ready = 1'b0;
        step();
        data_load = 1'b0;
        step();
        crc_ready = 1'b1;
        crc_out   = 16'h5566;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_byte($sformatf("ovr_b%0d", i), ovr_exp[i], i == 5);
            if (i == 2) chk("ovr_pulse", 32'(overrun_err), 32'd1);
            if (i == 3) chk("ovr_pulse_end", 32'(overrun_err), 32'd0);
            data_load = (i == 1);
            data_in   = (i == 1) ? 32'h89986996 : 32'h0;
        end
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("ovr_no_frame%0d", i), {30'd0, tx_valid, busy}, 32'd0);
        end

        // Timeout: crcReady stays low
        data_load = 1'b1;
        data_in   = 32'hdeadbeef;
        crc_ready = 1'b0;
        step();
        data_load = 1'b0;
        chk("to_busy_rise", 32'(busy), 32'd1);
        for (int k = 2; k <= 8; k++) begin
            step();
            chk($sformatf("to_wait%0d", k), {30'd0, timeout_err, tx_valid}, 32'd0);
        end
        chk("to_busy_hold", 32'(busy), 32'd1);
        step();
        chk("to_pulse", 32'(timeout_err), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        step();
        chk("to_pulse_end", 32'(timeout_err), 32'd0);
        chk("to_no_valid", 32'(tx_valid), 32'd0);

        // Spurious edge while IDLE
        crc_ready = 1'b1;
        step();
        step();
        chk("spur_idle", {30'd0, tx_valid, busy}, 32'd0);

        // Reset mid SEND_CRC
        data_load = 1'b1;
        data_in   = 32'h01020304;
        crc_ready = 1'b0;
        step();
        data_load = 1'b0;
        step();
        crc_ready = 1'b1;
        crc_out   = 16'habcd;
        for (int i = 0; i < 6; i++) step();
        chk_byte("mid_crc_last", 8'hcd, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async", {29'd0, tx_valid, tx_last, busy}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst_clean_idle", {30'd0, tx_valid, busy}, 32'd0);
        data_load = 1'b1;
        data_in   = 32'hcafef00d;
        crc_ready = 1'b0;
        step();
        data_load = 1'b0;
        step();
        crc_ready = 1'b1;
        crc_out   = 16'h0f0f;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_byte($sformatf("rst_b%0d", i), rst_exp[i], i == 5);
        end
        step();
        chk("rst_end", {30'd0, tx_valid, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
